// File: rtl/round_key_sequencer.sv
// rtl/round_key_sequencer.sv - registered AES round-key bank streaming keys over a valid/ready handshake
module round_key_sequencer #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  keyLoad,
   input  logic [(Nr+1)*128-1:0] keysIn,
   input  logic                  start,
   input  logic                  decrypt,
   output logic [127:0]          roundKey,
   output logic [3:0]            roundIdx,
   output logic                  rkValid,
   input  logic                  rkReady,
   output logic                  rkLast,
   output logic                  keysLoaded,
   output logic                  busy
);
   localparam logic [3:0] LAST_IDX = 4'(Nr);

   // AES ties the round count to the key length; catch mismatched overrides at elaboration.
   if (Nr != Nk + 6) begin : g_param_check
      $error("round_key_sequencer: Nr must equal Nk+6");
   end

   typedef enum logic [1:0] {EMPTY, IDLE, STREAM} state_t;

   state_t       state, state_next;
   logic         begin_stream;
   logic         xfer;
   logic         dec;
   logic [3:0]   first_idx;
   logic [3:0]   next_idx;
   logic [127:0] bank [Nr+1];

   function automatic logic is_last(input logic [3:0] idx, input logic rev);
      return rev ? (idx == 4'd0) : (idx == LAST_IDX);
   endfunction

   assign xfer      = rkValid & rkReady;
   assign first_idx = decrypt ? LAST_IDX : 4'd0;
   assign next_idx  = dec ? (roundIdx - 4'd1) : (roundIdx + 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // keyLoad takes priority over start in every state.
   always_comb begin
      state_next   = state;
      begin_stream = 1'b0;
      case (state)
         EMPTY:  if (keyLoad) state_next = IDLE;
         IDLE: begin
            if (start && !keyLoad) begin
               state_next   = STREAM;
               begin_stream = 1'b1;
            end
         end
         STREAM: if (keyLoad || (xfer && rkLast)) state_next = IDLE;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (keyLoad) begin
         for (int i = 0; i <= Nr; i++) bank[i] <= keysIn[(Nr+1)*128-1-i*128 -: 128];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         roundKey   <= '0;
         roundIdx   <= '0;
         rkValid    <= 1'b0;
         rkLast     <= 1'b0;
         keysLoaded <= 1'b0;
         busy       <= 1'b0;
         dec        <= 1'b0;
      end else begin
         if (keyLoad) keysLoaded <= 1'b1;
         if (begin_stream) begin
            dec      <= decrypt;
            roundIdx <= first_idx;
            roundKey <= bank[first_idx];
            rkLast   <= is_last(first_idx, decrypt);
            rkValid  <= 1'b1;
            busy     <= 1'b1;
         end else if (state == STREAM) begin
            // Abort or final transfer; roundKey/roundIdx keep their last values.
            if (keyLoad || (xfer && rkLast)) begin
               rkValid <= 1'b0;
               busy    <= 1'b0;
               rkLast  <= 1'b0;
            end else if (xfer) begin
               roundIdx <= next_idx;
               roundKey <= bank[next_idx];
               rkLast   <= is_last(next_idx, dec);
            end
         end
      end
   end
endmodule

// File: tb/tb_round_key_sequencer.sv
// tb/tb_round_key_sequencer.sv - scoreboard bench for round_key_sequencer
module tb_round_key_sequencer;
   localparam int NR = 10;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  keyLoad = 1'b0;
   logic [(NR+1)*128-1:0] keysIn = '0;
   logic                  start = 1'b0;
   logic                  decrypt = 1'b0;
   logic [127:0]          roundKey;
   logic [3:0]            roundIdx;
   logic                  rkValid;
   logic                  rkReady = 1'b0;
   logic                  rkLast;
   logic                  keysLoaded;
   logic                  busy;

   round_key_sequencer #(.Nk(4), .Nr(NR)) dut (
      .clk(clk), .rst_n(rst_n), .keyLoad(keyLoad), .keysIn(keysIn),
      .start(start), .decrypt(decrypt), .roundKey(roundKey), .roundIdx(roundIdx),
      .rkValid(rkValid), .rkReady(rkReady), .rkLast(rkLast),
      .keysLoaded(keysLoaded), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]   idx;
      logic [127:0] key;
      logic         last;
   } exp_t;

   int errors = 0;
   int checks = 0;
   int xfers = 0;
   int rmode = 0;
   int stall_cnt = 0;
   exp_t q[$];
   exp_t e;
   logic [127:0] mbank [0:NR];
   logic [127:0] nbank [0:NR];
   logic [127:0] fips [0:NR] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on each transfer and checks hold-stability while stalled.
   logic         prev_stall = 1'b0;
   logic [3:0]   pidx;
   logic [127:0] pkey;
   logic         plast;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall && rkValid) begin
            chk("stall_idx", roundIdx, pidx);
            chk("stall_key", roundKey, pkey);
            chk("stall_last", rkLast, plast);
         end
         if (rkValid && rkReady) begin
            xfers++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer: got idx %0d expected no transfer", roundIdx);
            end else begin
               e = q.pop_front();
               chk("xfer_idx", roundIdx, e.idx);
               chk("xfer_key", roundKey, e.key);
               chk("xfer_last", rkLast, e.last);
            end
         end
         prev_stall = rkValid && !rkReady;
         pidx  = roundIdx;
         pkey  = roundKey;
         plast = rkLast;
      end else begin
         prev_stall = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      case (rmode)
         0: rkReady = 1'b1;
         1: rkReady = 1'($urandom_range(0, 1));
         default: begin
            if (rkValid && roundIdx == 4'd4 && stall_cnt < 3) begin
               rkReady = 1'b0;
               stall_cnt++;
            end else begin
               rkReady = ~rkReady;
            end
         end
      endcase
   end

   task automatic random_nbank();
      for (int i = 0; i <= NR; i++) nbank[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic drive_keys();
      for (int i = 0; i <= NR; i++) keysIn[(NR+1)*128-1-i*128 -: 128] = nbank[i];
   endtask

   task automatic do_load();
      drive_keys();
      keyLoad = 1'b1;
      tick();
      keyLoad = 1'b0;
      for (int i = 0; i <= NR; i++) mbank[i] = nbank[i];
      chk("keysLoaded_after_load", keysLoaded, 1);
   endtask

   task automatic start_stream(input logic d);
      for (int k = 0; k <= NR; k++) begin
         int idx;
         idx = d ? NR - k : k;
         q.push_back('{idx: 4'(idx), key: mbank[idx], last: (k == NR)});
      end
      decrypt = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_valid", rkValid, 1);
      chk("start_busy", busy, 1);
      chk("start_idx", roundIdx, d ? NR : 0);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_busy_clear"}, busy, 0);
      chk({name, "_valid_clear"}, rkValid, 0);
      chk({name, "_last_clear"}, rkLast, 0);
      chk({name, "_queue_empty"}, q.size(), 0);
   endtask

   initial begin
      #12;
      chk("rst_key", roundKey, 0);
      chk("rst_idx", roundIdx, 0);
      chk("rst_valid", rkValid, 0);
      chk("rst_last", rkLast, 0);
      chk("rst_loaded", keysLoaded, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // start with no keys loaded
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("empty_start_valid", rkValid, 0);
      chk("empty_start_loaded", keysLoaded, 0);
      tick();
      chk("empty_start_busy", busy, 0);

      // FIPS-197 encrypt order
      for (int i = 0; i <= NR; i++) nbank[i] = fips[i];
      do_load();
      rmode = 0;
      xfers = 0;
      start_stream(1'b0);
      chk("fips_round0", roundKey, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_done("fips_enc");
      chk("fips_enc_xfers", xfers, 11);
      chk("fips_round10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("fips_enc_final_idx", roundIdx, 10);

      // decrypt order
      start_stream(1'b1);
      chk("fips_dec_first", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_done("fips_dec");
      chk("fips_dec_final_key", roundKey, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_dec_final_idx", roundIdx, 0);

      // backpressure with a 3-cycle stall at idx 4
      rmode = 2;
      stall_cnt = 0;
      xfers = 0;
      start_stream(1'b0);
      wait_done("stall");
      chk("stall_xfers", xfers, 11);
      chk("stall_cycles", stall_cnt, 3);

      // keyLoad and start together in IDLE
      rmode = 0;
      random_nbank();
      drive_keys();
      keyLoad = 1'b1;
      start = 1'b1;
      tick();
      keyLoad = 1'b0;
      start = 1'b0;
      for (int i = 0; i <= NR; i++) mbank[i] = nbank[i];
      chk("loadstart_valid", rkValid, 0);
      chk("loadstart_busy", busy, 0);
      tick();
      chk("loadstart_valid2", rkValid, 0);

      // abort at idx 5, then stream the new set
      start_stream(1'b0);
      begin
         int n;
         n = 0;
         while (!(rkValid && roundIdx == 4'd5) && n < 50) begin
            tick();
            n++;
         end
         chk("abort_reached_idx5", roundIdx, 5);
      end
      random_nbank();
      do_load();
      chk("abort_valid", rkValid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_last", rkLast, 0);
      q.delete();
      start_stream(1'b0);
      chk("abort_new_round0", roundKey, nbank[0]);
      wait_done("after_abort");

      // randomized loads, directions and ready patterns
      for (int r = 0; r < 6; r++) begin
         random_nbank();
         do_load();
         rmode = $urandom_range(0, 1);
         start_stream(1'($urandom_range(0, 1)));
         wait_done("random");
      end

      // asynchronous reset mid-stream
      rmode = 0;
      start_stream(1'b0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_key", roundKey, 0);
      chk("arst_idx", roundIdx, 0);
      chk("arst_valid", rkValid, 0);
      chk("arst_last", rkLast, 0);
      chk("arst_loaded", keysLoaded, 0);
      chk("arst_busy", busy, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_rst_start_valid", rkValid, 0);
      chk("post_rst_start_busy", busy, 0);
      chk("post_rst_loaded", keysLoaded, 0);
      tick();
      chk("post_rst_valid2", rkValid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
